// File: rtl/sonar_sched_pkg.sv
// Shared types and constants for the sonar vector scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sonar_sched_pkg;

    localparam int DEF_MAX_PARALLEL = 4;
    localparam int DEF_SEEK_W       = 64;
    localparam int DEF_VEC_W        = 16;

    // Width of a lane index; never narrower than one bit.
    function automatic int lane_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEF_LANE_IDX_W = lane_idx_w(DEF_MAX_PARALLEL);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_DISPATCH = 3'd2,
        ST_RUN      = 3'd3,
        ST_FLUSH    = 3'd4,
        ST_DRAIN    = 3'd5,
        ST_FINISH   = 3'd6
    } sched_state_t;

endpackage

// File: rtl/sonar_section_table.sv
// Per-vector section offset table: one slot per lane, filled in descriptor order.
// Latency: a write is visible on table_flat/nz_mask the cycle after wr_en.
// Backpressure: none; writes past the last slot are dropped and raise overflow.
//
// Ports: clk/rst (sync, active-high); clr_table empties slots and the write
// pointer; clr_ovf clears the overflow flag; wr_en/wr_offset append one entry;
// table_flat packs slot i at [i*SEEK_W +: SEEK_W]; nz_mask[i] = slot i non-empty.
module sonar_section_table
    import sonar_sched_pkg::*;
#(
    parameter int MAX_PARALLEL = DEF_MAX_PARALLEL,
    parameter int SEEK_W       = DEF_SEEK_W
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           clr_table,
    input  logic                           clr_ovf,
    input  logic                           wr_en,
    input  logic [SEEK_W-1:0]              wr_offset,
    output logic [MAX_PARALLEL*SEEK_W-1:0] table_flat,
    output logic [MAX_PARALLEL-1:0]        nz_mask,
    output logic                           overflow
);

    localparam int IDX_W = lane_idx_w(MAX_PARALLEL);
    // One extra bit so the pointer can sit at MAX_PARALLEL ("full").
    localparam int PTR_W = IDX_W + 1;
    localparam logic [PTR_W-1:0] PTR_FULL = PTR_W'(MAX_PARALLEL);

    logic [SEEK_W-1:0] slot_q [MAX_PARALLEL];
    logic [SEEK_W-1:0] slot_d [MAX_PARALLEL];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic              ovf_q, ovf_d;

    always_comb begin
        slot_d   = slot_q;
        wr_ptr_d = wr_ptr_q;
        ovf_d    = ovf_q;
        if (wr_en) begin
            if (wr_ptr_q < PTR_FULL) begin
                for (int i = 0; i < MAX_PARALLEL; i++) begin
                    if (wr_ptr_q == PTR_W'(i)) begin
                        slot_d[i] = wr_offset;
                    end
                end
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end else begin
                ovf_d = 1'b1;
            end
        end
        // Overflow survives per-vector clears so it can fail the whole run.
        if (clr_table) begin
            for (int i = 0; i < MAX_PARALLEL; i++) begin
                slot_d[i] = '0;
            end
            wr_ptr_d = '0;
        end
        if (clr_ovf) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MAX_PARALLEL; i++) begin
                slot_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            slot_q   <= slot_d;
            wr_ptr_q <= wr_ptr_d;
            ovf_q    <= ovf_d;
        end
    end

    always_comb begin
        table_flat = '0;
        nz_mask    = '0;
        for (int i = 0; i < MAX_PARALLEL; i++) begin
            table_flat[i*SEEK_W +: SEEK_W] = slot_q[i];
            nz_mask[i]                     = |slot_q[i];
        end
    end

    assign overflow = ovf_q;

endmodule

// File: rtl/sonar_vector_scheduler.sv
// Sequences test vectors over parallel stimulus lanes and folds lane errors into a verdict.
// Latency: start->busy 1 cycle; last descriptor->lane_start 1 cycle; lane_end->lane_flush 1 cycle.
// Backpressure: desc_ready only in LOAD; DRAIN stalls until every lane drops lane_busy.
//
// Ports: clk, rst (sync, active-high); start/vec_count begin a run; desc_valid/
// desc_ready/desc_offset/desc_last carry section descriptors; lane_start/
// lane_offset/lane_flush drive the lanes; lane_busy/lane_end/lane_error report
// back; vec_index, busy, done, error_sticky, overflow, pass report status.
module sonar_vector_scheduler
    import sonar_sched_pkg::*;
#(
    parameter int MAX_PARALLEL = DEF_MAX_PARALLEL,
    parameter int SEEK_W       = DEF_SEEK_W,
    parameter int VEC_W        = DEF_VEC_W
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [VEC_W-1:0]               vec_count,
    input  logic                           desc_valid,
    output logic                           desc_ready,
    input  logic [SEEK_W-1:0]              desc_offset,
    input  logic                           desc_last,
    output logic [MAX_PARALLEL-1:0]        lane_start,
    output logic [MAX_PARALLEL*SEEK_W-1:0] lane_offset,
    output logic [MAX_PARALLEL-1:0]        lane_flush,
    input  logic [MAX_PARALLEL-1:0]        lane_busy,
    input  logic [MAX_PARALLEL-1:0]        lane_end,
    input  logic [MAX_PARALLEL-1:0]        lane_error,
    output logic [VEC_W-1:0]               vec_index,
    output logic                           busy,
    output logic                           done,
    output logic [MAX_PARALLEL-1:0]        error_sticky,
    output logic                           overflow,
    output logic                           pass
);

    sched_state_t            state_q, state_d;
    logic [VEC_W-1:0]        vec_count_q, vec_count_d;
    logic [VEC_W-1:0]        vec_index_q, vec_index_d;
    logic [MAX_PARALLEL-1:0] err_q, err_d;
    logic                    pass_q, pass_d;

    logic                    tbl_clr;
    logic                    tbl_ovf_clr;
    logic                    tbl_wr;
    logic [MAX_PARALLEL-1:0] tbl_nz;
    logic                    tbl_ovf;

    sonar_section_table #(
        .MAX_PARALLEL (MAX_PARALLEL),
        .SEEK_W       (SEEK_W)
    ) u_table (
        .clk        (clk),
        .rst        (rst),
        .clr_table  (tbl_clr),
        .clr_ovf    (tbl_ovf_clr),
        .wr_en      (tbl_wr),
        .wr_offset  (desc_offset),
        .table_flat (lane_offset),
        .nz_mask    (tbl_nz),
        .overflow   (tbl_ovf)
    );

    always_comb begin
        state_d     = state_q;
        vec_count_d = vec_count_q;
        vec_index_d = vec_index_q;
        err_d       = err_q;
        pass_d      = pass_q;
        tbl_clr     = 1'b0;
        tbl_ovf_clr = 1'b0;
        tbl_wr      = 1'b0;
        desc_ready  = 1'b0;
        lane_start  = '0;
        lane_flush  = '0;
        done        = 1'b0;
        pass        = pass_q;

        if (state_q != ST_IDLE) begin
            err_d = err_q | lane_error;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    vec_count_d = vec_count;
                    vec_index_d = '0;
                    // An error pulse coincident with start belongs to the new run.
                    err_d       = lane_error;
                    pass_d      = 1'b0;
                    tbl_clr     = 1'b1;
                    tbl_ovf_clr = 1'b1;
                    state_d     = (vec_count == '0) ? ST_FINISH : ST_LOAD;
                end
            end
            ST_LOAD: begin
                desc_ready = 1'b1;
                if (desc_valid) begin
                    tbl_wr = 1'b1;
                    if (desc_last) begin
                        state_d = ST_DISPATCH;
                    end
                end
            end
            ST_DISPATCH: begin
                lane_start = tbl_nz;
                // A vector of only empty sections has nothing to wait for.
                state_d    = (tbl_nz == '0) ? ST_FLUSH : ST_RUN;
            end
            ST_RUN: begin
                if (|lane_end) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                lane_flush = '1;
                tbl_clr    = 1'b1;
                state_d    = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (lane_busy == '0) begin
                    vec_index_d = vec_index_q + VEC_W'(1);
                    state_d     = (vec_index_d == vec_count_q) ? ST_FINISH : ST_LOAD;
                end
            end
            ST_FINISH: begin
                done    = 1'b1;
                pass_d  = (err_d == '0) && !tbl_ovf;
                pass    = pass_d;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            vec_count_q <= '0;
            vec_index_q <= '0;
            err_q       <= '0;
            pass_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            vec_count_q <= vec_count_d;
            vec_index_q <= vec_index_d;
            err_q       <= err_d;
            pass_q      <= pass_d;
        end
    end

    assign vec_index    = vec_index_q;
    assign busy         = (state_q != ST_IDLE);
    assign error_sticky = err_q;
    assign overflow     = tbl_ovf;

endmodule

// File: tb/tb_sonar_vector_scheduler.sv
// Directed bench for sonar_vector_scheduler with a queue-based scoreboard.
// Latency: n/a.
// Backpressure: n/a.
module tb_sonar_vector_scheduler;

    localparam int MP = 4;
    localparam int SW = 64;
    localparam int VW = 16;
    localparam int CW = MP * SW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [VW-1:0] vec_count = '0;
    logic          desc_valid = 1'b0;
    logic          desc_ready;
    logic [SW-1:0] desc_offset = '0;
    logic          desc_last = 1'b0;
    logic [MP-1:0] lane_start;
    logic [CW-1:0] lane_offset;
    logic [MP-1:0] lane_flush;
    logic [MP-1:0] lane_busy = '0;
    logic [MP-1:0] lane_end = '0;
    logic [MP-1:0] lane_error = '0;
    logic [VW-1:0] vec_index;
    logic          busy;
    logic          done;
    logic [MP-1:0] error_sticky;
    logic          overflow;
    logic          pass;

    sonar_vector_scheduler #(.MAX_PARALLEL(MP), .SEEK_W(SW), .VEC_W(VW)) dut (
        .clk(clk), .rst(rst), .start(start), .vec_count(vec_count),
        .desc_valid(desc_valid), .desc_ready(desc_ready),
        .desc_offset(desc_offset), .desc_last(desc_last),
        .lane_start(lane_start), .lane_offset(lane_offset),
        .lane_flush(lane_flush), .lane_busy(lane_busy),
        .lane_end(lane_end), .lane_error(lane_error),
        .vec_index(vec_index), .busy(busy), .done(done),
        .error_sticky(error_sticky), .overflow(overflow), .pass(pass)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [MP-1:0] mask;
        logic [CW-1:0] offs;
    } st_ev_t;

    typedef struct {
        logic          pass_v;
        logic [MP-1:0] err;
        logic          ovf;
        logic [VW-1:0] vidx;
    } dn_ev_t;

    st_ev_t start_q[$];
    dn_ev_t done_q[$];

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops the oldest expectation whenever the DUT launches lanes or ends a run.
    always @(negedge clk) begin
        st_ev_t se;
        dn_ev_t de;
        if (!rst) begin
            if (lane_start != '0) begin
                if (start_q.size() == 0) begin
                    chk("unexpected_lane_start", CW'(lane_start), CW'(0));
                end else begin
                    se = start_q.pop_front();
                    chk("start_mask", CW'(lane_start), CW'(se.mask));
                    chk("start_offsets", lane_offset, se.offs);
                end
            end
            if (done) begin
                if (done_q.size() == 0) begin
                    chk("unexpected_done", CW'(done), CW'(0));
                end else begin
                    de = done_q.pop_front();
                    chk("done_pass", CW'(pass), CW'(de.pass_v));
                    chk("done_error_sticky", CW'(error_sticky), CW'(de.err));
                    chk("done_overflow", CW'(overflow), CW'(de.ovf));
                    chk("done_vec_index", CW'(vec_index), CW'(de.vidx));
                end
            end
        end
    end

    task automatic push_done(input logic p, input logic [MP-1:0] e, input logic o, input logic [VW-1:0] v);
        dn_ev_t d;
        d.pass_v = p;
        d.err    = e;
        d.ovf    = o;
        d.vidx   = v;
        done_q.push_back(d);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!desc_ready && n < 100) begin
            tick();
            n++;
        end
        chk("desc_ready_wait", CW'(desc_ready), CW'(1));
    endtask

    task automatic do_start(input logic [VW-1:0] cnt, input logic [MP-1:0] err);
        vec_count  = cnt;
        start      = 1'b1;
        lane_error = err;
        tick();
        start      = 1'b0;
        lane_error = '0;
        chk("start_busy", CW'(busy), CW'(1));
    endtask

    // One vector: load n descriptors, expect exp_m launched, end it with end_m,
    // inject err_m in RUN, keep lane 3 busy for busy_cyc DRAIN cycles.
    task automatic run_vector(input logic [SW-1:0] o0, input logic [SW-1:0] o1,
                              input logic [SW-1:0] o2, input logic [SW-1:0] o3,
                              input logic [SW-1:0] o4, input logic [SW-1:0] o5,
                              input int n, input logic [MP-1:0] exp_m,
                              input logic [MP-1:0] end_m, input logic [MP-1:0] err_m,
                              input int busy_cyc, input bit hold, input bit is_last);
        logic [SW-1:0] o [6];
        logic [CW-1:0] flat;
        st_ev_t        se;
        o[0] = o0; o[1] = o1; o[2] = o2; o[3] = o3; o[4] = o4; o[5] = o5;
        flat = '0;
        for (int i = 0; i < MP && i < n; i++) flat[i*SW +: SW] = o[i];
        wait_ready();
        if (exp_m != '0) begin
            se.mask = exp_m;
            se.offs = flat;
            start_q.push_back(se);
        end
        for (int k = 0; k < n; k++) begin
            desc_valid  = 1'b1;
            desc_offset = o[k];
            desc_last   = (k == n - 1);
            tick();
        end
        desc_valid  = 1'b0;
        desc_last   = 1'b0;
        desc_offset = '0;
        chk("dispatch_lane_start", CW'(lane_start), CW'(exp_m));
        if (exp_m != '0) begin
            tick();
            chk("run_no_flush", CW'(lane_flush), CW'(0));
            lane_end   = end_m;
            lane_error = err_m;
            tick();
            lane_error = '0;
            if (!hold) lane_end = '0;
        end else begin
            tick();
        end
        chk("flush_pulse", CW'(lane_flush), CW'({MP{1'b1}}));
        chk("flush_offsets_stable", lane_offset, flat);
        tick();
        chk("flush_one_cycle", CW'(lane_flush), CW'(0));
        chk("table_cleared", lane_offset, CW'(0));
        lane_busy = (busy_cyc > 0) ? {1'b1, {(MP-1){1'b0}}} : '0;
        for (int i = 0; i < busy_cyc; i++) begin
            chk("drain_hold", CW'({desc_ready, done}), CW'(0));
            tick();
        end
        lane_busy = '0;
        lane_end  = '0;
        tick();
        if (is_last) chk("finish_done", CW'(done), CW'(1));
        else         chk("next_load_ready", CW'(desc_ready), CW'(1));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    initial begin
        st_ev_t se;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        chk("reset_busy", CW'(busy), CW'(0));
        chk("reset_desc_ready", CW'(desc_ready), CW'(0));
        chk("reset_lane_start", CW'(lane_start), CW'(0));
        chk("reset_lane_flush", CW'(lane_flush), CW'(0));
        chk("reset_lane_offset", lane_offset, CW'(0));
        chk("reset_done", CW'(done), CW'(0));
        chk("reset_pass", CW'(pass), CW'(0));
        chk("reset_error_sticky", CW'(error_sticky), CW'(0));
        chk("reset_overflow", CW'(overflow), CW'(0));
        chk("reset_vec_index", CW'(vec_index), CW'(0));

        // Two vectors; a second start while busy must be ignored.
        push_done(1'b1, 4'b0000, 1'b0, 16'd2);
        do_start(16'd2, 4'b0000);
        vec_count = 16'd7;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        run_vector(64'h40, 64'h80, 0, 0, 0, 0, 2, 4'b0011, 4'b0001, 4'b0000, 0, 1'b0, 1'b0);
        run_vector(64'h100, 64'h0, 0, 0, 0, 0, 2, 4'b0001, 4'b0001, 4'b0000, 0, 1'b0, 1'b1);
        tick();
        chk("idle_after_run", CW'(busy), CW'(0));
        chk("vec_index_holds", CW'(vec_index), CW'(2));

        // Zero vectors: immediate finish.
        push_done(1'b1, 4'b0000, 1'b0, 16'd0);
        do_start(16'd0, 4'b0000);
        tick();
        chk("zero_run_idle", CW'(busy), CW'(0));

        // Zero vectors with an error pulse coincident with start.
        push_done(1'b0, 4'b0001, 1'b0, 16'd0);
        do_start(16'd0, 4'b0001);
        tick();
        chk("pass_holds", CW'(pass), CW'(0));
        chk("error_sticky_holds", CW'(error_sticky), CW'(1));

        // Six descriptors into four lanes.
        push_done(1'b0, 4'b0000, 1'b1, 16'd1);
        do_start(16'd1, 4'b0000);
        run_vector(64'h10, 64'h20, 64'h30, 64'h40, 64'h50, 64'h60, 6, 4'b1111, 4'b0001, 4'b0000, 0, 1'b0, 1'b1);
        tick();
        chk("overflow_holds", CW'(overflow), CW'(1));

        // Lane 2 error in vector 0 of 3.
        push_done(1'b0, 4'b0100, 1'b0, 16'd3);
        do_start(16'd3, 4'b0000);
        run_vector(64'h1000, 0, 0, 0, 0, 0, 1, 4'b0001, 4'b0001, 4'b0100, 0, 1'b0, 1'b0);
        run_vector(64'h2000, 64'h3000, 0, 0, 0, 0, 2, 4'b0011, 4'b0010, 4'b0000, 0, 1'b0, 1'b0);
        run_vector(64'h4000, 0, 0, 0, 0, 0, 1, 4'b0001, 4'b0001, 4'b0000, 0, 1'b0, 1'b1);
        tick();
        chk("error_run_sticky", CW'(error_sticky), CW'(4'b0100));

        // Held lane_end, slow drain, then an all-empty vector.
        push_done(1'b1, 4'b0000, 1'b0, 16'd2);
        do_start(16'd2, 4'b0000);
        run_vector(64'h200, 64'h300, 64'h0, 64'h400, 0, 0, 4, 4'b1011, 4'b0010, 4'b0000, 5, 1'b1, 1'b0);
        run_vector(64'h0, 0, 0, 0, 0, 0, 1, 4'b0000, 4'b0000, 4'b0000, 0, 1'b0, 1'b1);
        tick();

        // Reset in the middle of RUN.
        do_start(16'd1, 4'b0000);
        wait_ready();
        se.mask = 4'b0001;
        se.offs = CW'(64'h55);
        start_q.push_back(se);
        desc_valid  = 1'b1;
        desc_offset = 64'h55;
        desc_last   = 1'b1;
        tick();
        desc_valid  = 1'b0;
        desc_last   = 1'b0;
        desc_offset = '0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_busy", CW'(busy), CW'(0));
        chk("midrst_lane_offset", lane_offset, CW'(0));
        chk("midrst_desc_ready", CW'(desc_ready), CW'(0));
        chk("midrst_pass", CW'(pass), CW'(0));

        push_done(1'b1, 4'b0000, 1'b0, 16'd1);
        do_start(16'd1, 4'b0000);
        run_vector(64'h77, 0, 0, 0, 0, 0, 1, 4'b0001, 4'b0001, 4'b0000, 0, 1'b0, 1'b1);
        repeat (3) tick();

        chk("start_queue_empty", CW'(start_q.size()), CW'(0));
        chk("done_queue_empty", CW'(done_q.size()), CW'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
